// File: rtl/stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// stopwatch_ctrl
// Control front-end for a MM:SS stopwatch. It synchronizes and debounces the
// raw buttons and switches, turns button presses into single-cycle pulses,
// and runs a two-state RUN/HOLD machine. That machine produces the counter
// control strobes: clear, count one second, and adjust one field.
//
// Ports:
//   i_clk        master clock, all state changes on its rising edge
//   i_rst        synchronous active-low reset
//   i_sample_en  one-cycle debounce sample strobe (~250 Hz)
//   i_tick_1hz   one-cycle pulse, once per second
//   i_tick_2hz   one-cycle pulse, twice per second
//   i_rst_btn    raw reset push button, active-high
//   i_pause_btn  raw pause push button, active-high
//   i_adj_sw     raw adjust-mode slide switch, active-high
//   i_sel_sw     raw field-select slide switch (1 = seconds, 0 = minutes)
//   o_paused     1 while the stopwatch is held
//   o_clr        one-cycle pulse that zeroes the time counter
//   o_adj        debounced adjust switch level
//   o_sel        debounced select switch level
//   o_count_en   one-cycle pulse that advances the time by one second
//   o_adj_step   one-cycle pulse that increments the selected field
// ---------------------------------------------------------------------------
module stopwatch_ctrl #(
    parameter int DB_LEN = 3,
    parameter int CNT_W  = 3
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sample_en,
    input  logic i_tick_1hz,
    input  logic i_tick_2hz,
    input  logic i_rst_btn,
    input  logic i_pause_btn,
    input  logic i_adj_sw,
    input  logic i_sel_sw,
    output logic o_paused,
    output logic o_clr,
    output logic o_adj,
    output logic o_sel,
    output logic o_count_en,
    output logic o_adj_step
);

    localparam int NUM_IN = 4;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    // The counter value on which the next mismatching sample is the
    // DB_LEN-th one, so the level is accepted on that sample.
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_LEN - 1);

    // Input order: bit 0 rst_btn, bit 1 pause_btn, bit 2 adj_sw, bit 3 sel_sw
    logic [NUM_IN-1:0] w_raw;
    logic [NUM_IN-1:0] r_sync1;
    logic [NUM_IN-1:0] r_sync2;
    logic [NUM_IN-1:0] w_level;
    logic [1:0]        r_btnPrev;

    logic       w_rstPress;
    logic       w_pausePress;
    logic       w_adj;
    logic [0:0] r_state;
    logic       r_clr;
    logic       r_countEn;
    logic       r_adjStep;

    assign w_raw = {i_sel_sw, i_adj_sw, i_pause_btn, i_rst_btn};

    // Two-flop synchronizer for every raw input
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // One debouncer per input. A matching sample discards any partial count,
    // so only DB_LEN consecutive mismatching samples can move the level.
    for (genvar g = 0; g < NUM_IN; g++) begin : g_db
        logic [CNT_W-1:0] r_cnt;
        logic             r_lvl;

        always_ff @(posedge i_clk) begin
            if (!i_rst) begin
                r_cnt <= '0;
                r_lvl <= 1'b0;
            end else if (i_sample_en) begin
                if (r_sync2[g] == r_lvl) begin
                    r_cnt <= '0;
                end else if (r_cnt == DB_LAST) begin
                    r_lvl <= r_sync2[g];
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign w_level[g] = r_lvl;
    end

    // Previous debounced button levels, used for rising-edge detection
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_btnPrev <= '0;
        end else begin
            r_btnPrev <= w_level[1:0];
        end
    end

    // Press pulses are high for the single cycle after the level rises
    assign w_rstPress   = w_level[0] & ~r_btnPrev[0];
    assign w_pausePress = w_level[1] & ~r_btnPrev[1];
    assign w_adj        = w_level[2];

    // RUN/HOLD machine and registered control strobes. A reset press
    // overrides a pause press and also suppresses both tick strobes, so clr
    // never lines up with count_en or adj_step. Adjust mode only gates the
    // outputs and ignores pause, which leaves the RUN/HOLD state untouched
    // for when adjust mode is left.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state   <= ST_RUN;
            r_clr     <= 1'b0;
            r_countEn <= 1'b0;
            r_adjStep <= 1'b0;
        end else begin
            r_clr     <= w_rstPress;
            r_countEn <= i_tick_1hz & (r_state == ST_RUN) & ~w_adj & ~w_rstPress;
            r_adjStep <= i_tick_2hz & w_adj & ~w_rstPress;
            if (w_rstPress) begin
                r_state <= ST_RUN;
            end else if (w_pausePress && !w_adj) begin
                r_state <= (r_state == ST_RUN) ? ST_HOLD : ST_RUN;
            end
        end
    end

    assign o_paused   = (r_state == ST_HOLD);
    assign o_clr      = r_clr;
    assign o_adj      = w_level[2];
    assign o_sel      = w_level[3];
    assign o_count_en = r_countEn;
    assign o_adj_step = r_adjStep;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_ctrl
// Directed testbench for stopwatch_ctrl with DB_LEN=3. Inputs are driven on
// the falling edge and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_stopwatch_ctrl;

    logic clk;
    logic rst;
    logic sample_en;
    logic tick_1hz;
    logic tick_2hz;
    logic rst_btn;
    logic pause_btn;
    logic adj_sw;
    logic sel_sw;
    logic o_paused;
    logic o_clr;
    logic o_adj;
    logic o_sel;
    logic o_count_en;
    logic o_adj_step;

    int checks = 0;
    int errors = 0;

    stopwatch_ctrl #(.DB_LEN(3), .CNT_W(3)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_sample_en (sample_en),
        .i_tick_1hz  (tick_1hz),
        .i_tick_2hz  (tick_2hz),
        .i_rst_btn   (rst_btn),
        .i_pause_btn (pause_btn),
        .i_adj_sw    (adj_sw),
        .i_sel_sw    (sel_sw),
        .o_paused    (o_paused),
        .o_clr       (o_clr),
        .o_adj       (o_adj),
        .o_sel       (o_sel),
        .o_count_en  (o_count_en),
        .o_adj_step  (o_adj_step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // n sample strobes, each followed by an idle cycle. After the last one,
    // any press pulse has already been acted on by the FSM.
    task automatic strobe(input int n);
        repeat (n) begin
            sample_en = 1'b1;
            @(negedge clk);
            sample_en = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic setPause(input logic v);
        pause_btn = v;
        waitCycles(2);
        strobe(3);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        sample_en = 1'b1;
        tick_1hz = 1'b1;
        tick_2hz = 1'b1;
        waitCycles(3);
        checks++; if (o_paused !== 1'b0) begin errors++; $display("[TB] FAIL reset_paused: got %b expected 0", o_paused); end
        checks++; if (o_clr !== 1'b0) begin errors++; $display("[TB] FAIL reset_clr: got %b expected 0", o_clr); end
        checks++; if (o_adj !== 1'b0) begin errors++; $display("[TB] FAIL reset_adj: got %b expected 0", o_adj); end
        checks++; if (o_sel !== 1'b0) begin errors++; $display("[TB] FAIL reset_sel: got %b expected 0", o_sel); end
        checks++; if (o_count_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_count_en: got %b expected 0", o_count_en); end
        checks++; if (o_adj_step !== 1'b0) begin errors++; $display("[TB] FAIL reset_adj_step: got %b expected 0", o_adj_step); end
        rst = 1'b1;
        sample_en = 1'b0;
        tick_1hz = 1'b0;
        tick_2hz = 1'b0;
        waitCycles(2);
    endtask

    task automatic test_glitch;
        pause_btn = 1'b1;
        waitCycles(2);
        strobe(2);
        pause_btn = 1'b0;
        waitCycles(2);
        strobe(2);
        checks++; if (o_paused !== 1'b0) begin errors++; $display("[TB] FAIL glitch_first: paused=%b expected 0", o_paused); end
        // A second short glitch must not add to the first one
        pause_btn = 1'b1;
        waitCycles(2);
        strobe(2);
        pause_btn = 1'b0;
        waitCycles(2);
        strobe(2);
        checks++; if (o_paused !== 1'b0) begin errors++; $display("[TB] FAIL glitch_second: paused=%b expected 0", o_paused); end
    endtask

    task automatic test_run_count;
        tick_1hz = 1'b1;
        @(negedge clk);
        tick_1hz = 1'b0;
        checks++; if (o_count_en !== 1'b1) begin errors++; $display("[TB] FAIL run_count_en: got %b expected 1", o_count_en); end
        checks++; if (o_adj_step !== 1'b0) begin errors++; $display("[TB] FAIL run_adj_step: got %b expected 0", o_adj_step); end
        @(negedge clk);
        checks++; if (o_count_en !== 1'b0) begin errors++; $display("[TB] FAIL run_count_en_width: got %b expected 0", o_count_en); end
        tick_2hz = 1'b1;
        @(negedge clk);
        tick_2hz = 1'b0;
        checks++; if (o_adj_step !== 1'b0) begin errors++; $display("[TB] FAIL run_tick2_adj_step: got %b expected 0", o_adj_step); end
    endtask

    task automatic test_pause;
        setPause(1'b1);
        checks++; if (o_paused !== 1'b1) begin errors++; $display("[TB] FAIL pause_on: paused=%b expected 1", o_paused); end
        checks++; if (o_clr !== 1'b0) begin errors++; $display("[TB] FAIL pause_no_clr: clr=%b expected 0", o_clr); end
        waitCycles(4);
        checks++; if (o_paused !== 1'b1) begin errors++; $display("[TB] FAIL pause_held: paused=%b expected 1", o_paused); end
        tick_1hz = 1'b1;
        @(negedge clk);
        tick_1hz = 1'b0;
        checks++; if (o_count_en !== 1'b0) begin errors++; $display("[TB] FAIL pause_count_en: got %b expected 0", o_count_en); end
        setPause(1'b0);
        checks++; if (o_paused !== 1'b1) begin errors++; $display("[TB] FAIL pause_release: paused=%b expected 1", o_paused); end
        setPause(1'b1);
        checks++; if (o_paused !== 1'b0) begin errors++; $display("[TB] FAIL pause_off: paused=%b expected 0", o_paused); end
        setPause(1'b0);
        tick_1hz = 1'b1;
        checks++; if (o_count_en !== 1'b0) begin errors++; $display("[TB] FAIL resume_before_edge: count_en=%b expected 0", o_count_en); end
        @(negedge clk);
        tick_1hz = 1'b0;
        checks++; if (o_count_en !== 1'b1) begin errors++; $display("[TB] FAIL resume_count_en: got %b expected 1", o_count_en); end
        @(negedge clk);
        checks++; if (o_count_en !== 1'b0) begin errors++; $display("[TB] FAIL resume_count_en_width: got %b expected 0", o_count_en); end
    endtask

    task automatic test_reset_and_pause;
        rst_btn = 1'b1;
        pause_btn = 1'b1;
        waitCycles(2);
        strobe(2);
        sample_en = 1'b1;
        @(negedge clk);
        sample_en = 1'b0;
        tick_1hz = 1'b1;
        @(negedge clk);
        tick_1hz = 1'b0;
        checks++; if (o_clr !== 1'b1) begin errors++; $display("[TB] FAIL both_clr: got %b expected 1", o_clr); end
        checks++; if (o_paused !== 1'b0) begin errors++; $display("[TB] FAIL both_paused: got %b expected 0", o_paused); end
        checks++; if (o_count_en !== 1'b0) begin errors++; $display("[TB] FAIL both_count_en: got %b expected 0", o_count_en); end
        @(negedge clk);
        checks++; if (o_clr !== 1'b0) begin errors++; $display("[TB] FAIL both_clr_width: got %b expected 0", o_clr); end
        rst_btn = 1'b0;
        setPause(1'b0);
        checks++; if (o_clr !== 1'b0) begin errors++; $display("[TB] FAIL both_release_clr: got %b expected 0", o_clr); end
        checks++; if (o_paused !== 1'b0) begin errors++; $display("[TB] FAIL both_release_paused: got %b expected 0", o_paused); end
    endtask

    task automatic test_reset_from_hold;
        setPause(1'b1);
        setPause(1'b0);
        rst_btn = 1'b1;
        waitCycles(2);
        strobe(3);
        checks++; if (o_clr !== 1'b1) begin errors++; $display("[TB] FAIL hold_rst_clr: got %b expected 1", o_clr); end
        checks++; if (o_paused !== 1'b0) begin errors++; $display("[TB] FAIL hold_rst_paused: got %b expected 0", o_paused); end
        @(negedge clk);
        checks++; if (o_clr !== 1'b0) begin errors++; $display("[TB] FAIL hold_rst_clr_width: got %b expected 0", o_clr); end
        rst_btn = 1'b0;
        waitCycles(2);
        strobe(3);
        checks++; if (o_clr !== 1'b0) begin errors++; $display("[TB] FAIL hold_rst_release: clr=%b expected 0", o_clr); end
    endtask

    task automatic test_adjust;
        setPause(1'b1);
        setPause(1'b0);
        adj_sw = 1'b1;
        sel_sw = 1'b1;
        waitCycles(2);
        strobe(3);
        checks++; if (o_adj !== 1'b1) begin errors++; $display("[TB] FAIL adj_level: got %b expected 1", o_adj); end
        checks++; if (o_sel !== 1'b1) begin errors++; $display("[TB] FAIL sel_level: got %b expected 1", o_sel); end
        tick_2hz = 1'b1;
        @(negedge clk);
        tick_2hz = 1'b0;
        checks++; if (o_adj_step !== 1'b1) begin errors++; $display("[TB] FAIL adj_step: got %b expected 1", o_adj_step); end
        @(negedge clk);
        checks++; if (o_adj_step !== 1'b0) begin errors++; $display("[TB] FAIL adj_step_width: got %b expected 0", o_adj_step); end
        tick_1hz = 1'b1;
        @(negedge clk);
        tick_1hz = 1'b0;
        checks++; if (o_count_en !== 1'b0) begin errors++; $display("[TB] FAIL adj_count_en: got %b expected 0", o_count_en); end
        tick_1hz = 1'b1;
        tick_2hz = 1'b1;
        @(negedge clk);
        tick_1hz = 1'b0;
        tick_2hz = 1'b0;
        checks++; if (o_adj_step !== 1'b1) begin errors++; $display("[TB] FAIL adj_both_step: got %b expected 1", o_adj_step); end
        checks++; if (o_count_en !== 1'b0) begin errors++; $display("[TB] FAIL adj_both_count: got %b expected 0", o_count_en); end
        setPause(1'b1);
        checks++; if (o_paused !== 1'b1) begin errors++; $display("[TB] FAIL adj_pause_ignored: paused=%b expected 1", o_paused); end
        setPause(1'b0);
        sel_sw = 1'b0;
        waitCycles(2);
        strobe(3);
        checks++; if (o_sel !== 1'b0) begin errors++; $display("[TB] FAIL sel_minutes: got %b expected 0", o_sel); end
        checks++; if (o_adj !== 1'b1) begin errors++; $display("[TB] FAIL adj_kept: got %b expected 1", o_adj); end
        adj_sw = 1'b0;
        waitCycles(2);
        strobe(3);
        checks++; if (o_adj !== 1'b0) begin errors++; $display("[TB] FAIL adj_exit: got %b expected 0", o_adj); end
        checks++; if (o_paused !== 1'b1) begin errors++; $display("[TB] FAIL adj_exit_paused: got %b expected 1", o_paused); end
        tick_1hz = 1'b1;
        tick_2hz = 1'b1;
        @(negedge clk);
        tick_1hz = 1'b0;
        tick_2hz = 1'b0;
        checks++; if (o_count_en !== 1'b0) begin errors++; $display("[TB] FAIL hold_count_en: got %b expected 0", o_count_en); end
        checks++; if (o_adj_step !== 1'b0) begin errors++; $display("[TB] FAIL hold_adj_step: got %b expected 0", o_adj_step); end
        setPause(1'b1);
        setPause(1'b0);
        checks++; if (o_paused !== 1'b0) begin errors++; $display("[TB] FAIL adj_resume: paused=%b expected 0", o_paused); end
        tick_1hz = 1'b1;
        tick_2hz = 1'b1;
        @(negedge clk);
        tick_1hz = 1'b0;
        tick_2hz = 1'b0;
        checks++; if (o_count_en !== 1'b1) begin errors++; $display("[TB] FAIL run_both_count: got %b expected 1", o_count_en); end
        checks++; if (o_adj_step !== 1'b0) begin errors++; $display("[TB] FAIL run_both_step: got %b expected 0", o_adj_step); end
    endtask

    task automatic test_reset_midway;
        setPause(1'b1);
        setPause(1'b0);
        sel_sw = 1'b1;
        waitCycles(2);
        strobe(3);
        adj_sw = 1'b1;
        waitCycles(2);
        strobe(2);
        checks++; if (o_adj !== 1'b0) begin errors++; $display("[TB] FAIL mid_partial_adj: got %b expected 0", o_adj); end
        rst = 1'b0;
        sample_en = 1'b1;
        tick_1hz = 1'b1;
        tick_2hz = 1'b1;
        @(negedge clk);
        checks++; if (o_paused !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_paused: got %b expected 0", o_paused); end
        checks++; if (o_sel !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_sel: got %b expected 0", o_sel); end
        checks++; if (o_adj !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_adj: got %b expected 0", o_adj); end
        checks++; if (o_count_en !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_count_en: got %b expected 0", o_count_en); end
        checks++; if (o_adj_step !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_adj_step: got %b expected 0", o_adj_step); end
        rst = 1'b1;
        sample_en = 1'b0;
        tick_1hz = 1'b0;
        tick_2hz = 1'b0;
        waitCycles(2);
        strobe(2);
        checks++; if (o_adj !== 1'b0) begin errors++; $display("[TB] FAIL mid_two_samples: adj=%b expected 0", o_adj); end
        strobe(1);
        checks++; if (o_adj !== 1'b1) begin errors++; $display("[TB] FAIL mid_three_samples: adj=%b expected 1", o_adj); end
        checks++; if (o_sel !== 1'b1) begin errors++; $display("[TB] FAIL mid_sel_back: sel=%b expected 1", o_sel); end
        checks++; if (o_paused !== 1'b0) begin errors++; $display("[TB] FAIL mid_paused_after: got %b expected 0", o_paused); end
    endtask

    initial begin
        rst = 1'b0;
        sample_en = 1'b0;
        tick_1hz = 1'b0;
        tick_2hz = 1'b0;
        rst_btn = 1'b0;
        pause_btn = 1'b0;
        adj_sw = 1'b0;
        sel_sw = 1'b0;
        $display("[TB] stopwatch_ctrl directed test start");
        test_reset();
        test_glitch();
        test_run_count();
        test_pause();
        test_reset_and_pause();
        test_reset_from_hold();
        test_adjust();
        test_reset_midway();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter DB_LEN, default 3: consecutive sample_en samples at a new level needed to accept an input change.
REQ-002 Parameter CNT_W, default 3: width of each debounce counter; SHALL satisfy 2^CNT_W > DB_LEN.
REQ-003 clk  input  1  master clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-low.
REQ-005 sample_en  input  1  one-cycle debounce sample strobe from the clock divider, nominally ~250 Hz.
REQ-006 tick_1hz  input  1  one-cycle pulse, once per second.
REQ-007 tick_2hz  input  1  one-cycle pulse, twice per second.
REQ-008 rst_btn, pause_btn  input  1 each  raw asynchronous push buttons, active-high.
REQ-009 adj_sw, sel_sw  input  1 each  raw asynchronous slide switches, active-high.
REQ-010 paused  output  1  1 = stopwatch held.
REQ-011 clr  output  1  one-cycle pulse that zeroes the minute/second counter.
REQ-012 adj, sel  output  1 each  debounced switch levels; sel=1 selects seconds, sel=0 selects minutes.
REQ-013 count_en  output  1  one-cycle pulse that advances the time by one second.
REQ-014 adj_step  output  1  one-cycle pulse that increments the field chosen by sel.

Function
REQ-015 Each raw input SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-016 Debounce, per input:
- Hold a debounced level and a counter.
- On sample_en with synced value != level: increment the counter.
- On sample_en with synced value == level: clear the counter.
- When the counter would reach DB_LEN: the level takes the synced value on that edge and the counter clears.
- Without sample_en the counter holds.
REQ-017 The latency from a raw change to the debounced level SHALL be 2 sync cycles plus DB_LEN qualifying sample_en strobes. Glitches shorter than DB_LEN samples SHALL never change the level.
REQ-018 Press pulses SHALL be asserted for exactly one cycle, on the cycle after the debounced rst_btn or pause_btn level rises 0->1. Releases SHALL produce no pulse.
REQ-019 adj and sel SHALL be the registered debounced levels of adj_sw and sel_sw.
REQ-020 The control FSM SHALL have two states, RUN (paused=0) and HOLD (paused=1). paused SHALL be a direct decode of the state.
REQ-021 A pause press with adj=0 SHALL toggle RUN<->HOLD on the next edge. A pause press with adj=1 SHALL be ignored.
REQ-022 A reset press SHALL force the state to RUN and assert clr for exactly one cycle on the next edge, regardless of state or adj.
REQ-023 If a reset press and a pause press occur in the same cycle, reset SHALL win: state RUN, clr=1, no toggle.
REQ-024 count_en SHALL be the registered value of (tick_1hz AND state==RUN AND adj==0 AND no reset press this cycle); 1-cycle latency.
REQ-025 adj_step SHALL be the registered value of (tick_2hz AND adj==1 AND no reset press this cycle); 1-cycle latency.
REQ-026 count_en and adj_step SHALL never be asserted in the same cycle. clr SHALL never coincide with either of them.
REQ-027 Leaving adjust mode (adj 1->0) SHALL restore the prior RUN/HOLD state unchanged.
REQ-028 Simultaneous tick_1hz and tick_2hz SHALL be handled independently per REQ-024 and REQ-025; neither tick is lost or delayed.

Reset
REQ-029 When rst=0 at a rising edge, the following SHALL take effect on that edge, with sample_en and the ticks ignored:
- State RUN.
- paused=0, clr=0, adj=0, sel=0, count_en=0, adj_step=0.
- All synchronizer flops, debounced levels, debounce counters and press-pulse registers cleared to 0.
REQ-030 Reset asserted during an in-progress debounce SHALL discard the partial count. After release, a held-high raw input SHALL need the full DB_LEN samples again.

Verification
REQ-031 DB_LEN=3; pause_btn high for 2 sample_en, then low -> no pulse; paused stays 0.
REQ-032 pause_btn held high for 3 sample_en -> exactly one pause pulse; paused=1; subsequent tick_1hz produce count_en=0. A second press restores paused=0 and count_en follows tick_1hz with 1-cycle latency.
REQ-033 In RUN, rst_btn and pause_btn debounced on the same sample_en -> clr=1 for one cycle, paused=0; a tick_1hz in that cycle yields count_en=0.
REQ-034 adj_sw=1 while in HOLD:
- tick_2hz -> adj_step pulses; tick_1hz -> no count_en; pause presses ignored.
- adj_sw=0 -> paused still 1.
REQ-035 rst=0 after 2 of 3 qualifying samples on adj_sw -> all outputs 0. After rst=1, adj rises only after 3 further sample_en plus 2 sync cycles.
